// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU request arbiter: FSM encoding, ALU opcodes, default widths.
package alu_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_OP_W  = 4;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, contention goes to the one not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Optional grant statistics counters are enabled with `define ALU_REQ_ARBITER_STATS_EN.
module alu_req_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OP_W  = DEF_OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    input  logic [OP_W-1:0]  req1_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_REQ_ARBITER_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
`endif
    output logic             rsp_id
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
    logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic [1:0]       grant;

    rr_arb2 u_rr_arb2 (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Accept strobe is combinational; suppressed while reset is asserted.
    assign req_ready = (rst_n && (state_q == ST_IDLE)) ? grant : 2'b00;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_ready) begin
                    if (req_ready[1]) begin
                        alu_in1_d = req1_in1;
                        alu_in2_d = req1_in2;
                        alu_op_d  = req1_op;
                    end else begin
                        alu_in1_d = req0_in1;
                        alu_in2_d = req0_in2;
                        alu_op_d  = req0_op;
                    end
                    rsp_id_d     = req_ready[1];
                    last_grant_d = req_ready[1];
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_out;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign alu_in1   = alu_in1_q;
    assign alu_in2   = alu_in2_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef ALU_REQ_ARBITER_STATS_EN
    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

    // Saturating per-requester accept counters; clear beats a same-cycle increment.
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (stats_clr) begin
            grant_cnt0_d = '0;
            grant_cnt1_d = '0;
        end else begin
            if (req_ready[0] && (grant_cnt0_q != '1)) grant_cnt0_d = grant_cnt0_q + CNT_W'(1);
            if (req_ready[1] && (grant_cnt1_q != '1)) grant_cnt1_d = grant_cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized and directed bench for alu_req_arbiter against a transaction-level model.
module tb_alu_req_arbiter;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [15:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [3:0]  req0_op, req1_op, alu_op;
    logic [15:0] alu_in1, alu_in2, alu_out, rsp_data;
    logic        rsp_valid, rsp_ready, rsp_id;
`ifdef ALU_REQ_ARBITER_STATS_EN
    logic        stats_clr;
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_ADD:  return a + b;
            default: return ~(a ^ b);
        endcase
    endfunction

    assign alu_out = alu_f(alu_in1, alu_in2, alu_op);

    alu_req_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef ALU_REQ_ARBITER_STATS_EN
        .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .rsp_id(rsp_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Drive values applied one tick after each rising edge.
    logic        d_rst_n, d_rsp_ready, d_clr;
    logic [1:0]  d_valid;
    logic [15:0] d_a[2], d_b[2];
    logic [3:0]  d_op[2];

    // Transaction-level model: an in-flight operation, its age, and the outputs it implies.
    bit          m_busy, m_in_resp, m_last, m_rid;
    logic [15:0] m_res, m_rd, m_a1, m_a2;
    logic [3:0]  m_op;
    int          m_c0, m_c1;
    logic [1:0]  last_acc;
    int          cyc = 0;
    int          gq[$];
    int          gcyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_in_resp = 0; m_last = 1; m_rid = 0;
        m_res = '0; m_rd = '0; m_a1 = '0; m_a2 = '0; m_op = '0;
        m_c0 = 0; m_c1 = 0;
    endtask

    task automatic rand_req(input int i);
        d_a[i]  = 16'($urandom);
        d_b[i]  = 16'($urandom);
        d_op[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic step();
        logic [1:0] er;
        int g;
        @(posedge clk);
        #1;
        rst_n = d_rst_n; req_valid = d_valid; rsp_ready = d_rsp_ready;
        req0_in1 = d_a[0]; req0_in2 = d_b[0]; req0_op = d_op[0];
        req1_in1 = d_a[1]; req1_in2 = d_b[1]; req1_op = d_op[1];
`ifdef ALU_REQ_ARBITER_STATS_EN
        stats_clr = d_clr;
`endif
        @(negedge clk);
        er = 2'b00;
        if (!rst_n) model_reset();
        else if (!m_busy) begin
            if (req_valid == 2'b11) er = m_last ? 2'b01 : 2'b10;
            else er = req_valid;
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_in_resp));
        chk("rsp_data", 32'(rsp_data), 32'(m_rd));
        chk("rsp_id", 32'(rsp_id), 32'(m_rid));
        chk("alu_in1", 32'(alu_in1), 32'(m_a1));
        chk("alu_in2", 32'(alu_in2), 32'(m_a2));
        chk("alu_op", 32'(alu_op), 32'(m_op));
`ifdef ALU_REQ_ARBITER_STATS_EN
        chk("grant_cnt0", 32'(grant_cnt0), 32'(m_c0));
        chk("grant_cnt1", 32'(grant_cnt1), 32'(m_c1));
`endif
        last_acc = er;
        if (rst_n) begin
            if (d_clr) begin
                m_c0 = 0; m_c1 = 0;
            end else begin
                if (er[0] && m_c0 < 65535) m_c0++;
                if (er[1] && m_c1 < 65535) m_c1++;
            end
            if (m_busy) begin
                if (!m_in_resp) begin
                    m_in_resp = 1; m_rd = m_res;
                end else if (rsp_ready) begin
                    m_busy = 0;
                end
            end else if (er != 2'b00) begin
                g = er[1] ? 1 : 0;
                m_busy = 1; m_in_resp = 0; m_last = er[1]; m_rid = er[1];
                m_a1 = g ? req1_in1 : req0_in1;
                m_a2 = g ? req1_in2 : req0_in2;
                m_op = g ? req1_op : req0_op;
                m_res = alu_f(m_a1, m_a2, m_op);
                gq.push_back(g);
                gcyc.push_back(cyc);
            end
        end
        cyc++;
    endtask

    initial begin
        logic [15:0] s_data;
        logic [15:0] s_a1;
        int nv;
        int n1;
        rst_n = 0; req_valid = 0; rsp_ready = 0;
        req0_in1 = 0; req0_in2 = 0; req0_op = 0; req1_in1 = 0; req1_in2 = 0; req1_op = 0;
`ifdef ALU_REQ_ARBITER_STATS_EN
        stats_clr = 0;
`endif
        d_rst_n = 0; d_valid = 2'b11; d_rsp_ready = 0; d_clr = 0;
        for (int i = 0; i < 2; i++) rand_req(i);
        model_reset();

        // Reset: outputs zero, no accept even with both requesting.
        repeat (2) step();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_alu_in1", 32'(alu_in1), 32'h0);

        // Single request: AND of F0F0 and 0FF0.
        d_rst_n = 1; d_valid = 2'b01; d_rsp_ready = 1;
        d_a[0] = 16'hF0F0; d_b[0] = 16'h0FF0; d_op[0] = OP_AND;
        step();
        chk("tp1_ready", 32'(req_ready), 32'h1);
        d_valid = 2'b00;
        step();
        chk("tp1_exec_rsp_valid", 32'(rsp_valid), 32'h0);
        step();
        chk("tp1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("tp1_rsp_data", 32'(rsp_data), 32'h00F0);
        chk("tp1_rsp_id", 32'(rsp_id), 32'h0);
        step();

        // Continuous contention from a fresh reset: strict alternation, one grant per 3 cycles.
        d_rst_n = 0; step();
        d_rst_n = 1; d_valid = 2'b11; d_rsp_ready = 1;
        gq.delete(); gcyc.delete();
        repeat (18) begin
            step();
            for (int i = 0; i < 2; i++) if (last_acc[i]) rand_req(i);
        end
        chk("tp2_grant_count", 32'(gq.size()), 32'd6);
        for (int k = 0; k < 6 && k < gq.size(); k++) begin
            chk("tp2_grant_order", 32'(gq[k]), 32'(k % 2));
            if (k > 0) chk("tp2_issue_interval", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
        end
        d_valid = 2'b00;
        repeat (2) step();

        // Back-pressure: response held for 5 cycles, pending request not accepted.
        d_valid = 2'b10; rand_req(1); d_rsp_ready = 0;
        step();
        d_valid = 2'b01;
        step();
        step();
        s_data = rsp_data; s_a1 = alu_in1;
        chk("tp3_first_resp", 32'(rsp_valid), 32'h1);
        repeat (5) begin
            step();
            chk("tp3_hold_data", 32'(rsp_data), 32'(s_data));
            chk("tp3_hold_alu", 32'(alu_in1), 32'(s_a1));
            chk("tp3_hold_id", 32'(rsp_id), 32'h1);
            chk("tp3_no_ready", 32'(req_ready), 32'h0);
        end
        d_rsp_ready = 1;
        step();
        step();
        chk("tp3_next_accept", 32'(req_ready), 32'h1);
        d_valid = 2'b00;
        repeat (3) step();

        // Reset asserted while requester 1's operation is in EXEC.
        d_valid = 2'b10; d_a[1] = 16'h1234; d_b[1] = 16'h00FF; d_op[1] = OP_AND;
        step();
        d_valid = 2'b00;
        step();
        chk("tp4_in_exec_alu", 32'(alu_in1), 32'h1234);
        #2;
        rst_n = 0; d_rst_n = 0; req_valid = 2'b11;
        #1;
        chk("tp4_rst_req_ready", 32'(req_ready), 32'h0);
        chk("tp4_rst_alu_in1", 32'(alu_in1), 32'h0);
        chk("tp4_rst_alu_in2", 32'(alu_in2), 32'h0);
        chk("tp4_rst_alu_op", 32'(alu_op), 32'h0);
        chk("tp4_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("tp4_rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("tp4_rst_rsp_id", 32'(rsp_id), 32'h0);
        model_reset();
        step();
        d_rst_n = 1;
        nv = 0;
        repeat (4) begin
            step();
            nv += int'(rsp_valid);
        end
        chk("tp4_no_stale_rsp", 32'(nv), 32'h0);
        d_valid = 2'b11;
        step();
        chk("tp4_first_contention", 32'(req_ready), 32'h1);

        // Requester 1 pulses valid while requester 0 is in service.
        d_valid = 2'b10;
        n1 = 0; nv = 0;
        step();
        n1 += int'(req_ready[1]);
        d_valid = 2'b00;
        repeat (4) begin
            step();
            n1 += int'(req_ready[1]);
            nv += int'(rsp_valid);
        end
        chk("tp5_no_grant1", 32'(n1), 32'h0);
        chk("tp5_one_rsp", 32'(nv), 32'h1);

`ifdef ALU_REQ_ARBITER_STATS_EN
        d_rst_n = 0; step();
        d_rst_n = 1; d_valid = 2'b11;
        repeat (15) step();
        chk("stats_cnt0", 32'(grant_cnt0), 32'd3);
        chk("stats_cnt1", 32'(grant_cnt1), 32'd2);
        d_valid = 2'b00;
        step();
        d_valid = 2'b01; d_clr = 1;
        step();
        chk("stats_clr_accept", 32'(req_ready), 32'h1);
        d_valid = 2'b00; d_clr = 0;
        step();
        chk("stats_clr_cnt0", 32'(grant_cnt0), 32'd0);
        chk("stats_clr_cnt1", 32'(grant_cnt1), 32'd0);
        repeat (2) step();
`endif

        // Random traffic: legal holds, occasional withdrawals, random back-pressure and resets.
        repeat (3000) begin
            d_rst_n = ($urandom_range(0, 299) != 0);
            d_rsp_ready = ($urandom_range(0, 1) == 1);
            d_clr = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 2; i++) begin
                if (last_acc[i] || !d_valid[i]) begin
                    d_valid[i] = ($urandom_range(0, 2) != 0);
                    rand_req(i);
                end else if ($urandom_range(0, 9) == 0) begin
                    d_valid[i] = 1'b0;
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
